// File: rtl/mux_scan.sv
// Registered CHANNELS:1 word multiplexer. The select register is either
// loaded explicitly or stepped through every channel with a fixed dwell time.
module mux_scan #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic                      load,
  input  logic [SEL_W-1:0]          sel_in,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          sel_out,
  output logic                      step,
  output logic                      wrap,
  output logic                      err
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [SEL_W-1:0]  sel_r, sel_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s, cnt_adv_s;
  logic              step_r, step_s;
  logic              wrap_r, wrap_s;
  logic              err_r, err_s;
  logic              valid_load_s;
  logic [WIDTH-1:0]  data_r, word_s;

  // Word selection; an out-of-range select matches no channel and yields zero.
  always_comb begin
    word_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      word_s = word_s | ({WIDTH{sel_r == SEL_W'(k)}} & data_in[k*WIDTH +: WIDTH]);
    end
  end

  // Mode FSM plus select/dwell next state with load > scan advance priority.
  always_comb begin
    state_s      = state_r;
    sel_s        = sel_r;
    cnt_adv_s    = cnt_r;
    step_s       = 1'b0;
    wrap_s       = 1'b0;
    err_s        = 1'b0;
    valid_load_s = load & ({1'b0, sel_in} < CH_LIM);

    case (state_r)
      MANUAL:  if (mode) state_s = SCAN;   else state_s = MANUAL;
      SCAN:    if (mode) state_s = SCAN;   else state_s = MANUAL;
      default: state_s = MANUAL;
    endcase

    if (valid_load_s) begin
      sel_s     = sel_in;
      cnt_adv_s = '0;
      step_s    = (sel_in != sel_r);
    end else begin
      err_s = load;
      // Advancing only while staying in SCAN keeps sel intact across a mode change.
      if (state_r == SCAN && state_s == SCAN) begin
        if (cnt_r == CNT_LAST) begin
          cnt_adv_s = '0;
          step_s    = 1'b1;
          if (sel_r >= SEL_LAST) begin
            sel_s  = '0;
            wrap_s = 1'b1;
          end else begin
            sel_s = sel_r + 1'b1;
          end
        end else begin
          cnt_adv_s = cnt_r + 1'b1;
        end
      end else begin
        cnt_adv_s = cnt_r;
      end
    end

    if (state_s != state_r) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_adv_s;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= MANUAL;
      sel_r   <= '0;
      cnt_r   <= '0;
      step_r  <= 1'b0;
      wrap_r  <= 1'b0;
      err_r   <= 1'b0;
      data_r  <= '0;
    end else begin
      state_r <= state_s;
      sel_r   <= sel_s;
      cnt_r   <= cnt_s;
      step_r  <= step_s;
      wrap_r  <= wrap_s;
      err_r   <= err_s;
      data_r  <= word_s;
    end
  end

  assign data_out = data_r;
  assign sel_out  = sel_r;
  assign step     = step_r;
  assign wrap     = wrap_r;
  assign err      = err_r;

endmodule

// File: tb/tb_mux_scan.sv
// Self-checking bench for mux_scan: two configurations (4x8 bit dwell 3, 3x4 bit dwell 1)
// checked every cycle against a behavioural model, plus directed timing checks.
module tb_mux_scan;

  logic        clk;
  logic        rst;
  logic [31:0] a_din;
  logic        a_mode, a_load;
  logic [1:0]  a_sel;
  logic [7:0]  a_dout;
  logic [1:0]  a_sel_out;
  logic        a_step, a_wrap, a_err;
  logic [11:0] b_din;
  logic        b_mode, b_load;
  logic [1:0]  b_sel;
  logic [3:0]  b_dout;
  logic [1:0]  b_sel_out;
  logic        b_step, b_wrap, b_err;

  int n_tests = 0;
  int n_fail  = 0;

  mux_scan #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(3)) dut_a (
    .clk(clk), .rst(rst), .data_in(a_din), .mode(a_mode), .load(a_load), .sel_in(a_sel),
    .data_out(a_dout), .sel_out(a_sel_out), .step(a_step), .wrap(a_wrap), .err(a_err));

  mux_scan #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .data_in(b_din), .mode(b_mode), .load(b_load), .sel_in(b_sel),
    .data_out(b_dout), .sel_out(b_sel_out), .step(b_step), .wrap(b_wrap), .err(b_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit scan;
    int sel;
    int cnt;
    int dout;
    bit step;
    bit wrap;
    bit err;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mreset();
    mdl_t m;
    m.scan = 1'b0; m.sel = 0; m.cnt = 0; m.dout = 0;
    m.step = 1'b0; m.wrap = 1'b0; m.err = 1'b0;
    return m;
  endfunction

  // One clock edge of the specified behaviour, in plain integer terms.
  function automatic mdl_t mstep(mdl_t m, int nch, int dwell, int w, logic [31:0] din,
                                 bit mode, bit load, int sel_in);
    mdl_t n = m;
    n.step = 1'b0; n.wrap = 1'b0; n.err = 1'b0;
    n.dout = (m.sel < nch) ? int'((din >> (m.sel * w)) & ((32'd1 << w) - 32'd1)) : 0;
    if (load && sel_in < nch) begin
      n.step = (sel_in != m.sel);
      n.sel  = sel_in;
      n.cnt  = 0;
    end else begin
      if (load) n.err = 1'b1;
      if (m.scan && mode) begin
        if (m.cnt == dwell - 1) begin
          n.cnt  = 0;
          n.sel  = (m.sel + 1) % nch;
          n.step = 1'b1;
          n.wrap = (n.sel == 0);
        end else begin
          n.cnt = m.cnt + 1;
        end
      end
    end
    if (mode != m.scan) begin
      n.scan = mode;
      n.cnt  = 0;
    end
    return n;
  endfunction

  task automatic check(string tag, int obs, int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cmp_all();
    check("a_dout", int'(a_dout), ma.dout);
    check("a_sel",  int'(a_sel_out), ma.sel);
    check("a_step", int'(a_step), int'(ma.step));
    check("a_wrap", int'(a_wrap), int'(ma.wrap));
    check("a_err",  int'(a_err), int'(ma.err));
    check("b_dout", int'(b_dout), mb.dout);
    check("b_sel",  int'(b_sel_out), mb.sel);
    check("b_step", int'(b_step), int'(mb.step));
    check("b_wrap", int'(b_wrap), int'(mb.wrap));
    check("b_err",  int'(b_err), int'(mb.err));
  endtask

  task automatic check_zero(string tag);
    check({tag, "_a_dout"}, int'(a_dout), 0);
    check({tag, "_a_sel"},  int'(a_sel_out), 0);
    check({tag, "_a_flags"}, int'({a_step, a_wrap, a_err}), 0);
    check({tag, "_b_dout"}, int'(b_dout), 0);
    check({tag, "_b_sel"},  int'(b_sel_out), 0);
    check({tag, "_b_flags"}, int'({b_step, b_wrap, b_err}), 0);
  endtask

  task automatic tick();
    mdl_t na, nb;
    na = mstep(ma, 4, 3, 8, a_din, a_mode, a_load, int'(a_sel));
    nb = mstep(mb, 3, 1, 4, 32'(b_din), b_mode, b_load, int'(b_sel));
    @(posedge clk);
    #1;
    ma = na;
    mb = nb;
    cmp_all();
  endtask

  // Ticks until dut_a pulses step, giving up after 20 edges.
  task automatic wait_a_step(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!a_step && n < 20);
  endtask

  task automatic async_reset(string tag);
    #3 rst = 1'b1;
    #1;
    check_zero(tag);
    ma = mreset();
    mb = mreset();
    #1 rst = 1'b0;
  endtask

  int exp_seq [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int n, wraps, steps, wrap_at, bad;

  initial begin
    rst    = 1'b1;
    a_din  = {8'h44, 8'h33, 8'h22, 8'h11};
    a_mode = 1'b0; a_load = 1'b0; a_sel = 2'd0;
    b_din  = {4'hC, 4'hB, 4'hA};
    b_mode = 1'b0; b_load = 1'b0; b_sel = 2'd0;
    ma = mreset();
    mb = mreset();
    #12;
    check_zero("in_reset");
    rst = 1'b0;

    // Release and manual load.
    tick();
    check("rel_dout", int'(a_dout), 8'h11);
    a_load = 1'b1; a_sel = 2'd2;
    tick();
    a_load = 1'b0;
    check("ld_sel", int'(a_sel_out), 2);
    check("ld_step", int'(a_step), 1);
    tick();
    check("ld_dout", int'(a_dout), 8'h33);

    // Scan timing from sel 0.
    a_load = 1'b1; a_sel = 2'd0;
    tick();
    a_load = 1'b0;
    a_mode = 1'b1;
    tick();
    check("seq_0", int'(a_sel_out), exp_seq[0]);
    wraps = 0; steps = 0; wrap_at = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("seq_%0d", i), int'(a_sel_out), exp_seq[i]);
      if (a_wrap) begin wraps++; wrap_at = i; end
      if (a_step) steps++;
    end
    check("scan_wraps", wraps, 1);
    check("scan_wrap_at", wrap_at, 12);
    check("scan_steps", steps, 4);

    // Load 3 on the edge where sel=1 would advance to 2.
    for (int i = 0; i < 5; i++) tick();
    check("pre_expiry_sel", int'(a_sel_out), 1);
    a_load = 1'b1; a_sel = 2'd3;
    tick();
    a_load = 1'b0;
    check("expiry_sel", int'(a_sel_out), 3);
    wait_a_step(n);
    check("expiry_dwell", n, 3);
    check("expiry_wrap_sel", int'(a_sel_out), 0);
    check("expiry_wrap", int'(a_wrap), 1);

    // Leave scan at sel 2, hold, re-enter.
    n = 0;
    while (a_sel_out != 2'd2 && n < 20) begin tick(); n++; end
    check("reach_sel2", int'(a_sel_out), 2);
    a_mode = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_sel_out != 2'd2 || a_step) bad++;
    end
    check("manual_hold", bad, 0);
    a_mode = 1'b1;
    tick();
    wait_a_step(n);
    check("reenter_dwell", n, 3);
    check("reenter_sel", int'(a_sel_out), 3);

    // Reload the current channel: no step, dwell restarts.
    tick();
    a_load = 1'b1; a_sel = 2'd3;
    tick();
    a_load = 1'b0;
    check("reload_step", int'(a_step), 0);
    check("reload_sel", int'(a_sel_out), 3);
    wait_a_step(n);
    check("reload_dwell", n, 3);

    // Three channels, dwell 1: invalid select in manual then in scan.
    b_load = 1'b1; b_sel = 2'd3;
    tick();
    b_load = 1'b0;
    check("inv_err", int'(b_err), 1);
    check("inv_sel", int'(b_sel_out), 0);
    check("inv_step", int'(b_step), 0);
    tick();
    check("inv_err_once", int'(b_err), 0);
    b_mode = 1'b1;
    tick();
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("d1_sel_%0d", i), int'(b_sel_out), i % 3);
      check($sformatf("d1_wrap_%0d", i), int'(b_wrap), int'(i % 3 == 0));
    end
    b_load = 1'b1; b_sel = 2'd3;
    tick();
    b_load = 1'b0;
    check("inv_scan_err", int'(b_err), 1);
    check("inv_scan_sel", int'(b_sel_out), 1);
    check("inv_scan_step", int'(b_step), 1);

    // Asynchronous reset between edges while scanning.
    async_reset("mid_scan_rst");

    // Randomised phase.
    for (int i = 0; i < 3000; i++) begin
      a_din  = $urandom;
      b_din  = 12'($urandom);
      a_load = ($urandom_range(0, 5) == 0);
      b_load = ($urandom_range(0, 5) == 0);
      a_sel  = 2'($urandom_range(0, 3));
      b_sel  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) a_mode = ~a_mode;
      if ($urandom_range(0, 39) == 0) b_mode = ~b_mode;
      if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
